// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the serial memory loader: command codes, bus types and FSM state encodings.
package uart_mem_loader_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_HALT  = 8'h48;

  localparam int unsigned MIPS_ADDR_WIDTH = 32;
  localparam int unsigned MIPS_DATA_WIDTH = 32;

  typedef logic [MIPS_ADDR_WIDTH-1:0] mips_addr_t;
  typedef logic [MIPS_DATA_WIDTH-1:0] mips_data_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART byte receiver with 2-FF input synchronizer, start-bit glitch rejection and framing-error report.
module uart_loader_rx
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_ferr
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta, rx_sync, rx_prev;
  rx_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0] bit_idx, bit_next;
  logic [7:0] shreg, sh_next;
  logic valid_next, ferr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      shreg      <= sh_next;
      byte_valid <= valid_next;
      rx_ferr    <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    sh_next    = shreg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = RX_START;
          cnt_next   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (rx_sync) begin
            state_next = RX_IDLE;
          end else begin
            state_next = RX_DATA;
            bit_next   = '0;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          sh_next  = {rx_sync, shreg[7:1]};
          bit_next = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = RX_STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx_sync) begin
            valid_next = 1'b1;
            state_next = RX_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = RX_WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/uart_mem_loader.sv
// Serial boot loader: parses 'W' addr data / 'G' / 'H' commands from the UART and drives single-cycle bus writes.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CYCLES = 17360,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic                  bus_wr_en,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           load_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0] rx_byte;
  logic byte_valid, rx_ferr;

  loader_state_t state, state_next;
  logic [1:0] byte_cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [TW-1:0] to_cnt;
  logic timeout;

  logic clr_byte_cnt, shift_addr, shift_data, err_set, set_run, set_halt;

  uart_loader_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .rx_ferr   (rx_ferr)
  );

  assign timeout = (to_cnt == TO_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    clr_byte_cnt = 1'b0;
    shift_addr   = 1'b0;
    shift_data   = 1'b0;
    err_set      = 1'b0;
    set_run      = 1'b0;
    set_halt     = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid) begin
          case (rx_byte)
            CMD_WRITE: begin
              if (!cpu_rst_n) begin
                state_next   = ADDR;
                clr_byte_cnt = 1'b1;
              end else begin
                err_set = 1'b1;
              end
            end
            CMD_GO:   set_run  = 1'b1;
            CMD_HALT: set_halt = 1'b1;
            default:  err_set  = 1'b1;
          endcase
        end else if (rx_ferr) begin
          err_set = 1'b1;
        end
      end
      ADDR: begin
        if (rx_ferr) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (byte_valid) begin
          shift_addr = 1'b1;
          if (byte_cnt == 2'd3) state_next = DATA;
        end else if (timeout) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      DATA: begin
        if (rx_ferr) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (byte_valid) begin
          shift_data = 1'b1;
          if (byte_cnt == 2'd3) begin
            if (addr_sr[1:0] == 2'b00) begin
              state_next = WRITE;
            end else begin
              err_set    = 1'b1;
              state_next = IDLE;
            end
          end
        end else if (timeout) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // byte_cnt is 2 bits, so it wraps to 0 between the address and data phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      to_cnt   <= '0;
    end else begin
      if (clr_byte_cnt)                  byte_cnt <= '0;
      else if (shift_addr || shift_data) byte_cnt <= byte_cnt + 1'b1;
      if (shift_addr) addr_sr <= {addr_sr[ADDR_WIDTH-9:0], rx_byte};
      if (shift_data) data_sr <= {data_sr[DATA_WIDTH-9:0], rx_byte};
      if (state == IDLE || state == WRITE || byte_valid) to_cnt <= '0;
      else                                               to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_wr_en   <= 1'b0;
      cpu_rst_n   <= 1'b0;
      err         <= 1'b0;
      load_count  <= '0;
    end else begin
      bus_wr_en <= (state == WRITE);
      if (state == WRITE) begin
        bus_addr    <= addr_sr;
        bus_wr_data <= data_sr;
        load_count  <= load_count + 1'b1;
      end
      if (err_set) err <= 1'b1;
      if (set_run)       cpu_rst_n <= 1'b1;
      else if (set_halt) cpu_rst_n <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: command table, hand-written corner cases and random frames vs. a model.
module tb_uart_mem_loader;

  localparam int CPB = 8;
  localparam int TO  = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic        bus_wr_en;
  logic        cpu_rst_n;
  logic        busy;
  logic        err;
  logic [15:0] load_count;

  uart_mem_loader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TO),
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .bus_addr   (bus_addr),
    .bus_wr_data(bus_wr_data),
    .bus_wr_en  (bus_wr_en),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .err        (err),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t wr_q[$];
  int en_cycles = 0;
  int en_rises  = 0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (bus_wr_en === 1'b1) begin
      en_cycles++;
      if (!en_prev) begin
        en_rises++;
        wr_q.push_back('{bus_addr, bus_wr_data, cyc});
      end
    end
    en_prev = (bus_wr_en === 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_q.delete();
  endtask

  task automatic expect_writes(input string tag, input int n, input logic [31:0] a, input logic [31:0] d);
    int lat;
    chk({tag, " write count"}, wr_q.size(), n);
    if (n == 1 && wr_q.size() == 1) begin
      lat = wr_q[0].c - last_start;
      chk({tag, " bus_addr"}, wr_q[0].a, a);
      chk({tag, " bus_wr_data"}, wr_q[0].d, d);
      // Strobe lands two cycles after the last byte is recognised, i.e. near the end of its stop bit.
      chk({tag, " latency"}, (lat >= 9 * CPB + CPB / 2) && (lat <= 11 * CPB), 1);
    end
    wr_q.delete();
  endtask

  typedef struct {
    logic        do_rst;
    logic [7:0]  cmd;
    logic [31:0] a;
    logic [31:0] d;
    int          exp_wr;
    logic        exp_err;
    logic        exp_cpu;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_err;
    logic        m_cpu;
    logic [15:0] m_cnt;
    logic [31:0] ra, rd;
    int          op;

    vt[0] = '{1'b0, 8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 16'd1};
    vt[1] = '{1'b0, 8'h47, 32'h0,         32'h0,         0, 1'b0, 1'b1, 16'd1};
    vt[2] = '{1'b0, 8'h57, 32'h0000_0030, 32'h1234_5678, 0, 1'b1, 1'b1, 16'd1};
    vt[3] = '{1'b0, 8'h48, 32'h0,         32'h0,         0, 1'b1, 1'b0, 16'd1};
    vt[4] = '{1'b1, 8'h57, 32'h0000_0012, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 16'd0};
    vt[5] = '{1'b0, 8'h57, 32'h0000_0104, 32'h0BAD_F00D, 1, 1'b1, 1'b0, 16'd1};

    rst_n = 1'b0;
    rx    = 1'b1;
    do_reset();

    chk("reset bus_addr", bus_addr, 0);
    chk("reset bus_wr_data", bus_wr_data, 0);
    chk("reset bus_wr_en", bus_wr_en, 0);
    chk("reset cpu_rst_n", cpu_rst_n, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset load_count", load_count, 0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (vt[v].do_rst) do_reset();
      if (vt[v].cmd == 8'h57) send_frame(vt[v].a, vt[v].d);
      else                    send_byte(vt[v].cmd, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      expect_writes(tag, vt[v].exp_wr, vt[v].a, vt[v].d);
      chk({tag, " err"}, err, vt[v].exp_err);
      chk({tag, " cpu_rst_n"}, cpu_rst_n, vt[v].exp_cpu);
      chk({tag, " load_count"}, load_count, vt[v].exp_cnt);
      chk({tag, " busy"}, busy, 0);
    end

    // Inter-byte timeout discards a partial frame.
    do_reset();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("timeout busy mid-frame", busy, 1);
    repeat (500) @(posedge clk);
    #1;
    chk("timeout busy after", busy, 0);
    chk("timeout err", err, 1);
    send_frame(32'h0000_0020, 32'h5A5A_A5A5);
    repeat (4) @(posedge clk);
    #1;
    expect_writes("after-timeout", 1, 32'h0000_0020, 32'h5A5A_A5A5);
    chk("after-timeout load_count", load_count, 1);

    // Short low glitch must not be taken as a start bit; bad stop bit aborts a frame.
    do_reset();
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    chk("glitch busy", busy, 0);
    chk("glitch err", err, 0);
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("ferr busy before", busy, 1);
    send_byte(8'h11, 1'b0);
    chk("ferr busy after", busy, 0);
    chk("ferr err", err, 1);
    chk("ferr no write", wr_q.size(), 0);

    // Random frames and run/halt toggles against the model.
    do_reset();
    m_err = 1'b0;
    m_cpu = 1'b0;
    m_cnt = '0;
    for (int it = 0; it < 14; it++) begin
      string tag;
      tag = $sformatf("rand%0d", it);
      op = $urandom_range(0, 3);
      if (op == 2) begin
        send_byte(8'h47, 1'b1);
        m_cpu = 1'b1;
        chk({tag, " go cpu_rst_n"}, cpu_rst_n, m_cpu);
        send_byte(8'h48, 1'b1);
        m_cpu = 1'b0;
        chk({tag, " halt cpu_rst_n"}, cpu_rst_n, m_cpu);
      end else begin
        ra = $urandom;
        rd = $urandom;
        if (op == 1) ra[1:0] = 2'($urandom_range(1, 3));
        else         ra[1:0] = 2'b00;
        send_frame(ra, rd);
        repeat (4) @(posedge clk);
        #1;
        if (ra[1:0] == 2'b00) begin
          m_cnt = m_cnt + 16'd1;
          expect_writes(tag, 1, ra, rd);
        end else begin
          m_err = 1'b1;
          expect_writes(tag, 0, ra, rd);
        end
      end
      chk({tag, " err"}, err, m_err);
      chk({tag, " load_count"}, load_count, m_cnt);
      chk({tag, " busy"}, busy, 0);
    end

    // Asynchronous reset in the middle of the data phase.
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h40 >> (8 * (3 - i)), 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    chk("midreset busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset bus_addr", bus_addr, 0);
    chk("midreset bus_wr_data", bus_wr_data, 0);
    chk("midreset bus_wr_en", bus_wr_en, 0);
    chk("midreset cpu_rst_n", cpu_rst_n, 0);
    chk("midreset busy", busy, 0);
    chk("midreset err", err, 0);
    chk("midreset load_count", load_count, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    send_frame(32'h8000_0004, 32'h0000_0041);
    repeat (4) @(posedge clk);
    #1;
    expect_writes("csr", 1, 32'h8000_0004, 32'h0000_0041);
    chk("csr load_count", load_count, 1);
    chk("csr err", err, 0);

    chk("bus_wr_en single-cycle pulses", en_cycles, en_rises);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
